// File: rtl/uart_report_scheduler_pkg.sv
// rtl/uart_report_scheduler_pkg.sv - shared states, frame constants and frame byte helpers
package uart_report_scheduler_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} sched_state_e;

    localparam logic [7:0] MARKER   = 8'h00;
    localparam logic [1:0] DATA_TAG = 2'b01;
    localparam logic       FREQ_TAG = 1'b1;

    function automatic logic [2:0] frame_len(input logic send_freq);
        return send_freq ? 3'd5 : 3'd4;
    endfunction

    // Without the frequency byte the frame starts at the fixed 0x00 byte.
    function automatic logic [7:0] frame_byte(input logic [6:0]  freq,
                                              input logic [15:0] err,
                                              input logic [2:0]  idx,
                                              input logic        send_freq);
        logic [2:0] pos;
        pos = send_freq ? idx : idx + 3'd1;
        case (pos)
            3'd0:    frame_byte = {FREQ_TAG, freq};
            3'd2:    frame_byte = {DATA_TAG, err[5:0]};
            3'd3:    frame_byte = {DATA_TAG, err[11:6]};
            3'd4:    frame_byte = {DATA_TAG, 2'b00, err[15:12]};
            default: frame_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/uart_report_scheduler_fifo.sv
// rtl/uart_report_scheduler_fifo.sv - record FIFO with valid/ready push and pop strobe
module report_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 25
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_valid_i,
    output logic         push_ready_o,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    logic          push, pop;

    // Occupancy carries one extra bit so full and empty never alias.
    assign full_o       = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o      = (cnt_q == '0);
    assign push_ready_o = !full_o;
    assign push         = push_valid_i && !full_o;
    assign pop          = pop_i && !empty_o;
    assign pop_data_o   = mem_q[rd_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/uart_report_scheduler.sv
// rtl/uart_report_scheduler.sv - serializes queued result records and end marker onto one UART
module uart_report_scheduler
    import uart_report_scheduler_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 10000,
    parameter bit SEND_FREQ  = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        reset_counter,
    input  logic        rpt_valid,
    output logic        rpt_ready,
    input  logic [8:0]  rpt_freq,
    input  logic [15:0] rpt_errors,
    input  logic        mark_req,
    output logic        mark_ack,
    output logic [7:0]  UART_data,
    output logic        send_UART_data,
    output logic        frame_done,
    output logic        busy
);
    localparam int              CW       = ($clog2(GAP_CYCLES) > 16) ? $clog2(GAP_CYCLES) : 16;
    localparam logic [CW-1:0]   GAP_END  = CW'(GAP_CYCLES - 2);
    localparam logic [2:0]      LAST_IDX = frame_len(SEND_FREQ) - 3'd1;

    sched_state_e  state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [8:0]    freq_q, freq_d;
    logic [15:0]   err_q, err_d;
    logic          marker_q, marker_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          fifo_pop, fifo_empty, fifo_full;
    logic [24:0]   head;
    logic          unused_freq_hi;

    assign unused_freq_hi = ^freq_q[8:7];

    report_fifo #(.DEPTH(DEPTH), .W(25)) u_fifo (
        .clk_i        (CLOCK_50),
        .rst_i        (reset_counter),
        .push_valid_i (rpt_valid),
        .push_ready_o (rpt_ready),
        .push_data_i  ({rpt_freq, rpt_errors}),
        .pop_i        (fifo_pop),
        .pop_data_o   (head),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full)
    );

    assign UART_data = data_q;
    assign busy      = !(state_q == ST_IDLE && fifo_empty && !pend_q);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        freq_d         = freq_q;
        err_d          = err_q;
        marker_d       = marker_q;
        cnt_d          = cnt_q;
        data_d         = data_q;
        pend_d         = pend_q | mark_req;
        fifo_pop       = 1'b0;
        send_UART_data = 1'b0;
        mark_ack       = 1'b0;
        frame_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                end else if (pend_q) begin
                    marker_d = 1'b1;
                    data_d   = MARKER;
                    state_d  = ST_SEND;
                end
            end
            ST_LOAD: begin
                fifo_pop        = 1'b1;
                {freq_d, err_d} = head;
                idx_d           = 3'd0;
                marker_d        = 1'b0;
                data_d          = frame_byte(head[22:16], head[15:0], 3'd0, SEND_FREQ);
                state_d         = ST_SEND;
            end
            ST_SEND: begin
                send_UART_data = 1'b1;
                cnt_d          = '0;
                state_d        = ST_GAP;
                if (marker_q) begin
                    mark_ack = 1'b1;
                    pend_d   = mark_req;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + 1'b1;
                // Leaving at GAP_CYCLES-2 puts successive strobes exactly GAP_CYCLES apart.
                if (cnt_q == GAP_END) begin
                    if (!marker_q && idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 3'd1;
                        data_d  = frame_byte(freq_q[6:0], err_q, idx_q + 3'd1, SEND_FREQ);
                        state_d = ST_SEND;
                    end else begin
                        frame_done = !marker_q;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset_counter) begin
        if (reset_counter) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            freq_q   <= '0;
            err_q    <= '0;
            marker_q <= 1'b0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            freq_q   <= freq_d;
            err_q    <= err_d;
            marker_q <= marker_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_uart_report_scheduler.sv
// tb/tb_uart_report_scheduler.sv - randomized scenario bench with a byte-stream reference model
module tb_uart_report_scheduler;

    logic        CLOCK_50 = 1'b0;
    logic        reset_counter = 1'b1;
    logic        rv0 = 0, mr0 = 0, rv1 = 0, mr1 = 0;
    logic [8:0]  rf0 = 0, rf1 = 0;
    logic [15:0] re0 = 0, re1 = 0;
    logic        rdy0, ack0, send0, fd0, busy0;
    logic        rdy1, ack1, send1, fd1, busy1;
    logic [7:0]  data0, data1;

    always #5 CLOCK_50 = ~CLOCK_50;

    uart_report_scheduler #(.DEPTH(4), .GAP_CYCLES(8), .SEND_FREQ(1'b1)) u0 (
        .CLOCK_50(CLOCK_50), .reset_counter(reset_counter), .rpt_valid(rv0), .rpt_ready(rdy0),
        .rpt_freq(rf0), .rpt_errors(re0), .mark_req(mr0), .mark_ack(ack0), .UART_data(data0),
        .send_UART_data(send0), .frame_done(fd0), .busy(busy0));

    uart_report_scheduler #(.DEPTH(4), .GAP_CYCLES(8), .SEND_FREQ(1'b0)) u1 (
        .CLOCK_50(CLOCK_50), .reset_counter(reset_counter), .rpt_valid(rv1), .rpt_ready(rdy1),
        .rpt_freq(rf1), .rpt_errors(re1), .mark_req(mr1), .mark_ack(ack1), .UART_data(data1),
        .send_UART_data(send1), .frame_done(fd1), .busy(busy1));

    int checks = 0, failures = 0, tmo = 0, cyc = 0, stray = 0;
    logic        clr = 1'b0;
    logic [8:0]  cap_b[$];
    int          cap_c[$], fd_c[$];
    logic [7:0]  cap1_b[$];
    int          cap1_c[$], fd1_c[$];
    logic [8:0]  exp_b[$];
    bit          exp_first[$];
    int          exp_fd[$];

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (clr) begin
            cap_b.delete(); cap_c.delete(); fd_c.delete();
            cap1_b.delete(); cap1_c.delete(); fd1_c.delete();
            stray = 0;
        end else begin
            if (send0) begin cap_b.push_back({ack0, data0}); cap_c.push_back(cyc); end
            if (ack0 && !send0) stray++;
            if (fd0) fd_c.push_back(cyc);
            if (send1) begin cap1_b.push_back(data1); cap1_c.push_back(cyc); end
            if (fd1) fd1_c.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        reset_counter = 1'b1;
        rv0 = 0; mr0 = 0; rv1 = 0; mr1 = 0;
        repeat (3) tick();
        reset_counter = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_b.delete(); exp_first.delete(); exp_fd.delete();
        tmo = 0;
    endtask

    // Holds valid after acceptance; caller drops it or pushes again immediately.
    task automatic push_rec(input bit sel, input logic [8:0] f, input logic [15:0] e);
        int n = 0;
        if (sel) begin rv1 = 1; rf1 = f; re1 = e; end
        else     begin rv0 = 1; rf0 = f; re0 = e; end
        while (((sel ? rdy1 : rdy0) !== 1'b1) && n < 500) begin tick(); n++; end
        if (n >= 500) tmo++;
        tick();
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        tick();
        while (((sel ? busy1 : busy0) !== 1'b0) && n < 3000) begin tick(); n++; end
        if (n >= 3000) tmo++;
        repeat (20) tick();
    endtask

    task automatic wait_bytes(input int cnt);
        int n = 0;
        while (cap_b.size() < cnt && n < 500) begin tick(); n++; end
        if (n >= 500) tmo++;
    endtask

    task automatic model_rec(input logic [8:0] f, input logic [15:0] e);
        int b[5];
        b[0] = 128 + f % 128;
        b[1] = 0;
        b[2] = 64 + e % 64;
        b[3] = 64 + (e / 64) % 64;
        b[4] = 64 + e / 4096;
        for (int i = 0; i < 5; i++) begin
            exp_b.push_back({1'b0, 8'(b[i])});
            exp_first.push_back(i == 0);
        end
        exp_fd.push_back(exp_b.size() - 1);
    endtask

    task automatic model_marker();
        exp_b.push_back({1'b1, 8'h00});
        exp_first.push_back(1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (data0 !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data0); end
        checks++; if (send0 !== 1'b0) begin failures++; $display("FAIL reset_send got=%b exp=0", send0); end
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack0); end
        checks++; if (fd0 !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", fd0); end
        checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rdy0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
        checks++;
        if ({data1, send1, ack1, fd1, rdy1, busy1} !== {8'h00, 5'b00010}) begin
            failures++; $display("FAIL reset_u1 got=%h exp=%h", {data1, send1, ack1, fd1, rdy1, busy1}, {8'h00, 5'b00010});
        end
    endtask

    task automatic test_single();
        logic [8:0] f; logic [15:0] e;
        do_reset();
        push_rec(0, 9'h12B, 16'hABCD); rv0 = 0; model_rec(9'h12B, 16'hABCD);
        wait_idle(0);
        f = 9'($urandom); e = 16'($urandom);
        push_rec(0, f, e); rv0 = 0; model_rec(f, e);
        wait_idle(0);
        checks++; if (tmo != 0) begin failures++; $display("FAIL single_timeout got=%0d exp=0", tmo); end
        checks++; if (cap_b.size() != exp_b.size()) begin failures++; $display("FAIL single_nbytes got=%0d exp=%0d", cap_b.size(), exp_b.size()); end
        if (cap_b.size() >= 5) begin
            checks++;
            if ({cap_b[0][7:0], cap_b[1][7:0], cap_b[2][7:0], cap_b[3][7:0], cap_b[4][7:0]} !== 40'hAB004D6F4A) begin
                failures++; $display("FAIL single_fixed got=%h exp=ab004d6f4a", {cap_b[0][7:0], cap_b[1][7:0], cap_b[2][7:0], cap_b[3][7:0], cap_b[4][7:0]});
            end
        end
        foreach (exp_b[i]) if (i < cap_b.size()) begin
            checks++; if (cap_b[i] !== exp_b[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, cap_b[i], exp_b[i]); end
            if (!exp_first[i]) begin checks++; if (cap_c[i] - cap_c[i-1] != 8) begin failures++; $display("FAIL single_gap%0d got=%0d exp=8", i, cap_c[i] - cap_c[i-1]); end end
        end
        checks++; if (fd_c.size() != exp_fd.size()) begin failures++; $display("FAIL single_nframe_done got=%0d exp=%0d", fd_c.size(), exp_fd.size()); end
        foreach (exp_fd[k]) if (k < fd_c.size() && exp_fd[k] < cap_c.size()) begin
            checks++; if (fd_c[k] != cap_c[exp_fd[k]] + 7) begin failures++; $display("FAIL single_fd_time%0d got=%0d exp=%0d", k, fd_c[k], cap_c[exp_fd[k]] + 7); end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] f; logic [15:0] e;
        do_reset();
        f = 9'($urandom); e = 16'($urandom);
        push_rec(0, f, e); rv0 = 0; model_rec(f, e);
        wait_bytes(1);
        for (int k = 0; k < 5; k++) begin
            f = 9'($urandom); e = 16'($urandom);
            push_rec(0, f, e); model_rec(f, e);
            if (k == 3) begin
                checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL b2b_ready_full got=%b exp=0", rdy0); end
            end
        end
        rv0 = 0;
        wait_idle(0);
        checks++; if (tmo != 0) begin failures++; $display("FAIL b2b_timeout got=%0d exp=0", tmo); end
        checks++; if (cap_b.size() != exp_b.size()) begin failures++; $display("FAIL b2b_nbytes got=%0d exp=%0d", cap_b.size(), exp_b.size()); end
        foreach (exp_b[i]) if (i < cap_b.size()) begin
            checks++; if (cap_b[i] !== exp_b[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, cap_b[i], exp_b[i]); end
            if (!exp_first[i]) begin checks++; if (cap_c[i] - cap_c[i-1] != 8) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=8", i, cap_c[i] - cap_c[i-1]); end end
        end
        checks++; if (fd_c.size() != exp_fd.size()) begin failures++; $display("FAIL b2b_nframe_done got=%0d exp=%0d", fd_c.size(), exp_fd.size()); end
        foreach (exp_fd[k]) if (k < fd_c.size() && exp_fd[k] < cap_c.size()) begin
            checks++; if (fd_c[k] != cap_c[exp_fd[k]] + 7) begin failures++; $display("FAIL b2b_fd_time%0d got=%0d exp=%0d", k, fd_c[k], cap_c[exp_fd[k]] + 7); end
        end
    endtask

    task automatic test_marker_in_frame();
        logic [8:0] f; logic [15:0] e;
        do_reset();
        f = 9'($urandom); e = 16'($urandom);
        push_rec(0, f, e); rv0 = 0; model_rec(f, e);
        wait_bytes(1);
        f = 9'($urandom); e = 16'($urandom);
        push_rec(0, f, e); rv0 = 0; model_rec(f, e);
        mr0 = 1; tick(); mr0 = 0; model_marker();
        wait_idle(0);
        checks++; if (tmo != 0) begin failures++; $display("FAIL mark_frame_timeout got=%0d exp=0", tmo); end
        checks++; if (stray != 0) begin failures++; $display("FAIL mark_frame_stray_ack got=%0d exp=0", stray); end
        checks++; if (cap_b.size() != exp_b.size()) begin failures++; $display("FAIL mark_frame_nbytes got=%0d exp=%0d", cap_b.size(), exp_b.size()); end
        foreach (exp_b[i]) if (i < cap_b.size()) begin
            checks++; if (cap_b[i] !== exp_b[i]) begin failures++; $display("FAIL mark_frame_byte%0d got=%h exp=%h", i, cap_b[i], exp_b[i]); end
            if (!exp_first[i]) begin checks++; if (cap_c[i] - cap_c[i-1] != 8) begin failures++; $display("FAIL mark_frame_gap%0d got=%0d exp=8", i, cap_c[i] - cap_c[i-1]); end end
        end
        checks++; if (fd_c.size() != exp_fd.size()) begin failures++; $display("FAIL mark_frame_nframe_done got=%0d exp=%0d", fd_c.size(), exp_fd.size()); end
        foreach (exp_fd[k]) if (k < fd_c.size() && exp_fd[k] < cap_c.size()) begin
            checks++; if (fd_c[k] != cap_c[exp_fd[k]] + 7) begin failures++; $display("FAIL mark_frame_fd_time%0d got=%0d exp=%0d", k, fd_c[k], cap_c[exp_fd[k]] + 7); end
        end
    endtask

    task automatic test_marker_same_cycle();
        logic [8:0] f; logic [15:0] e;
        do_reset();
        f = 9'($urandom); e = 16'($urandom);
        rv0 = 1; rf0 = f; re0 = e; mr0 = 1;
        tick();
        rv0 = 0; mr0 = 0; model_rec(f, e);
        tick(); mr0 = 1; tick(); mr0 = 0; model_marker();
        wait_idle(0);
        checks++; if (tmo != 0) begin failures++; $display("FAIL mark_same_timeout got=%0d exp=0", tmo); end
        checks++; if (stray != 0) begin failures++; $display("FAIL mark_same_stray_ack got=%0d exp=0", stray); end
        checks++; if (cap_b.size() != exp_b.size()) begin failures++; $display("FAIL mark_same_nbytes got=%0d exp=%0d", cap_b.size(), exp_b.size()); end
        foreach (exp_b[i]) if (i < cap_b.size()) begin
            checks++; if (cap_b[i] !== exp_b[i]) begin failures++; $display("FAIL mark_same_byte%0d got=%h exp=%h", i, cap_b[i], exp_b[i]); end
            if (!exp_first[i]) begin checks++; if (cap_c[i] - cap_c[i-1] != 8) begin failures++; $display("FAIL mark_same_gap%0d got=%0d exp=8", i, cap_c[i] - cap_c[i-1]); end end
        end
        checks++; if (fd_c.size() != exp_fd.size()) begin failures++; $display("FAIL mark_same_nframe_done got=%0d exp=%0d", fd_c.size(), exp_fd.size()); end
    endtask

    task automatic test_reset_mid();
        int n_before;
        do_reset();
        for (int k = 0; k < 3; k++) push_rec(0, 9'($urandom), 16'($urandom));
        rv0 = 0;
        wait_bytes(3);
        reset_counter = 1'b1;
        #1;
        checks++; if (data0 !== 8'h00) begin failures++; $display("FAIL rst_mid_data got=%h exp=00", data0); end
        checks++;
        if ({send0, ack0, fd0, rdy0, busy0} !== 5'b00010) begin
            failures++; $display("FAIL rst_mid_flags got=%b exp=00010", {send0, ack0, fd0, rdy0, busy0});
        end
        repeat (2) tick();
        reset_counter = 1'b0;
        n_before = cap_b.size();
        repeat (200) tick();
        checks++; if (tmo != 0) begin failures++; $display("FAIL rst_mid_timeout got=%0d exp=0", tmo); end
        checks++; if (cap_b.size() != n_before) begin failures++; $display("FAIL rst_mid_strobes got=%0d exp=%0d", cap_b.size(), n_before); end
        checks++; if ({rdy0, busy0} !== 2'b10) begin failures++; $display("FAIL rst_mid_idle got=%b exp=10", {rdy0, busy0}); end
    endtask

    task automatic test_nofreq();
        logic [7:0] x[8];
        logic [15:0] e;
        do_reset();
        push_rec(1, 9'($urandom), 16'h0000); rv1 = 0;
        wait_idle(1);
        e = 16'($urandom);
        push_rec(1, 9'($urandom), e); rv1 = 0;
        wait_idle(1);
        x[0] = 8'h00; x[1] = 8'h40; x[2] = 8'h40; x[3] = 8'h40;
        x[4] = 8'h00; x[5] = 8'(64 + e % 64); x[6] = 8'(64 + (e / 64) % 64); x[7] = 8'(64 + e / 4096);
        checks++; if (tmo != 0) begin failures++; $display("FAIL nofreq_timeout got=%0d exp=0", tmo); end
        checks++; if (cap1_b.size() != 8) begin failures++; $display("FAIL nofreq_nbytes got=%0d exp=8", cap1_b.size()); end
        for (int i = 0; i < 8; i++) if (i < cap1_b.size()) begin
            checks++; if (cap1_b[i] !== x[i]) begin failures++; $display("FAIL nofreq_byte%0d got=%h exp=%h", i, cap1_b[i], x[i]); end
            if (i % 4 != 0) begin checks++; if (cap1_c[i] - cap1_c[i-1] != 8) begin failures++; $display("FAIL nofreq_gap%0d got=%0d exp=8", i, cap1_c[i] - cap1_c[i-1]); end end
        end
        checks++; if (fd1_c.size() != 2) begin failures++; $display("FAIL nofreq_nframe_done got=%0d exp=2", fd1_c.size()); end
        for (int k = 0; k < 2; k++) if (k < fd1_c.size() && 4 * k + 3 < cap1_c.size()) begin
            checks++; if (fd1_c[k] != cap1_c[4*k+3] + 7) begin failures++; $display("FAIL nofreq_fd_time%0d got=%0d exp=%0d", k, fd1_c[k], cap1_c[4*k+3] + 7); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_marker_in_frame();
        test_marker_same_cycle();
        test_reset_mid();
        test_nofreq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
